// File: rtl/jam_detect_if.sv
// Lane sensor and jam-sequencing signals shared between the jam detector and its environment.
// master drives the sensors and sys_en; slave is the jam_detect_ctrl side.
interface jam_detect_if;
    logic       sys_en;
    logic [3:0] car_in;
    logic [3:0] car_out;
    logic [3:0] traffic_jam;
    logic       jam_opp_en;
    logic       jam_start;
    logic       jam_rotation;

    modport master (
        output sys_en, car_in, car_out,
        input  traffic_jam, jam_opp_en, jam_start, jam_rotation
    );

    modport slave (
        input  sys_en, car_in, car_out,
        output traffic_jam, jam_opp_en, jam_start, jam_rotation
    );
endinterface

// File: rtl/jam_detect_ctrl.sv
// Per-lane queue counters with hysteretic jam flags, plus the IDLE/ACTIVE jam-mode sequencer.
// Optional JAM_DEBOUNCE_EN: flag changes need DEB_CYCLES consecutive cycles of their condition.
module jam_detect_ctrl #(
    parameter int CNT_W      = 5,
    parameter int JAM_ON     = 8,
    parameter int JAM_OFF    = 4,
    parameter int ROT_CYCLES = 16,
    parameter int DEB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    jam_detect_if.slave   bus
);
    localparam int N_LANES = 4;
    localparam int ROT_W   = $clog2(ROT_CYCLES);

    localparam logic [CNT_W-1:0] L_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] L_JAM_ON   = CNT_W'(JAM_ON);
    localparam logic [CNT_W-1:0] L_JAM_OFF  = CNT_W'(JAM_OFF);
    localparam logic [ROT_W-1:0] L_ROT_LAST = ROT_W'(ROT_CYCLES - 1);

    generate
        if (JAM_OFF >= JAM_ON || ROT_CYCLES < 2 || DEB_CYCLES < 1) begin : g_bad_params
            $error("jam_detect_ctrl: inconsistent parameters");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [CNT_W-1:0]   r_cnt [N_LANES];
    logic [N_LANES-1:0] r_flag;
    logic [N_LANES-1:0] w_set;
    logic [N_LANES-1:0] w_clr;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROT_W-1:0]   r_rot_cnt;
    logic [ROT_W-1:0]   w_rot_cnt_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic               r_rot;
    logic               w_rot_nxt;
    logic               w_any_jam;

    // NOTE: the counter array is reset element by element so no lane starts with a stale count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LANES; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                // NOTE: non-blocking so every lane and the FSM see pre-edge values of each other.
                if (bus.car_in[i] && !bus.car_out[i] && r_cnt[i] != L_CNT_MAX)
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (bus.car_out[i] && !bus.car_in[i] && r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_set[i] = (r_cnt[i] >= L_JAM_ON);
            w_clr[i] = (r_cnt[i] <= L_JAM_OFF);
        end
    end

`ifdef JAM_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] L_DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0]   r_deb [N_LANES];
    logic [N_LANES-1:0] w_chg;

    // A lane wants to change only when its condition opposes the current flag.
    assign w_chg = (w_set & ~r_flag) | (w_clr & r_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
            for (int i = 0; i < N_LANES; i++) r_deb[i] <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (!w_chg[i]) begin
                    r_deb[i] <= '0;
                end else if (r_deb[i] == L_DEB_LAST) begin
                    r_flag[i] <= ~r_flag[i];
                    r_deb[i]  <= '0;
                end else begin
                    r_deb[i] <= r_deb[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (w_set[i])      r_flag[i] <= 1'b1;
                else if (w_clr[i]) r_flag[i] <= 1'b0;
            end
        end
    end
`endif

    assign w_any_jam = |r_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rot_cnt <= '0;
            r_start   <= 1'b0;
            r_rot     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rot_cnt <= w_rot_cnt_nxt;
            r_start   <= w_start_nxt;
            r_rot     <= w_rot_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_rot_cnt_nxt = r_rot_cnt;
        w_start_nxt   = 1'b0;
        w_rot_nxt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.sys_en && w_any_jam) begin
                    w_state_nxt   = S_ACTIVE;
                    w_start_nxt   = 1'b1;
                    w_rot_cnt_nxt = '0;
                end
            end
            S_ACTIVE: begin
                // Exits win over a rotation due on the same edge.
                if (!bus.sys_en || !w_any_jam) begin
                    w_state_nxt   = S_IDLE;
                    w_rot_cnt_nxt = '0;
                end else if (r_rot_cnt == L_ROT_LAST) begin
                    w_rot_nxt     = 1'b1;
                    w_rot_cnt_nxt = '0;
                end else begin
                    w_rot_cnt_nxt = r_rot_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.traffic_jam  = r_flag;
    assign bus.jam_opp_en   = (r_state == S_ACTIVE);
    assign bus.jam_start    = r_start;
    assign bus.jam_rotation = r_rot;

endmodule

// File: tb/tb_jam_detect_ctrl.sv
// Randomised and directed bench for jam_detect_ctrl against an arithmetic reference model.
// Model tracks lane counts as integers and jam mode as "cycles since jam_start".
module tb_jam_detect_ctrl;
    localparam int JAM_ON     = 8;
    localparam int JAM_OFF    = 4;
    localparam int ROT_CYCLES = 16;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_MAX    = 31;

    logic clk;
    logic rst_n;
    jam_detect_if bus ();

    jam_detect_ctrl #(
        .CNT_W(5), .JAM_ON(JAM_ON), .JAM_OFF(JAM_OFF),
        .ROT_CYCLES(ROT_CYCLES), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int         m_cnt [4];
    int         m_deb [4];
    logic [3:0] m_flag;
    logic       m_active;
    logic       m_start;
    logic       m_rot;
    int         m_age;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_deb[i] = 0;
        end
        m_flag = '0; m_active = 0; m_start = 0; m_rot = 0; m_age = 0;
    endtask

    task automatic model_step(input logic s, input logic [3:0] ci, input logic [3:0] co);
        logic any_old;
        any_old = |m_flag;
        for (int i = 0; i < 4; i++) begin
            logic set_c, clr_c;
            set_c = (m_cnt[i] >= JAM_ON);
            clr_c = (m_cnt[i] <= JAM_OFF);
`ifdef JAM_DEBOUNCE_EN
            if ((set_c && !m_flag[i]) || (clr_c && m_flag[i])) begin
                m_deb[i]++;
                if (m_deb[i] == DEB_CYCLES) begin
                    m_flag[i] = ~m_flag[i];
                    m_deb[i]  = 0;
                end
            end else begin
                m_deb[i] = 0;
            end
`else
            if (set_c)      m_flag[i] = 1'b1;
            else if (clr_c) m_flag[i] = 1'b0;
`endif
            m_cnt[i] = m_cnt[i] + int'(ci[i]) - int'(co[i]);
            if (m_cnt[i] > CNT_MAX) m_cnt[i] = CNT_MAX;
            if (m_cnt[i] < 0)       m_cnt[i] = 0;
        end
        m_start = 0;
        m_rot   = 0;
        if (!m_active) begin
            if (s && any_old) begin
                m_active = 1; m_start = 1; m_age = 0;
            end
        end else if (!s || !any_old) begin
            m_active = 0;
        end else begin
            m_age++;
            m_rot = (m_age % ROT_CYCLES == 0);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit after the edge.
    task automatic cyc(input logic s, input logic [3:0] ci, input logic [3:0] co);
        bus.sys_en  = s;
        bus.car_in  = ci;
        bus.car_out = co;
        @(posedge clk);
        model_step(s, ci, co);
        #1;
        bus.car_in  = '0;
        bus.car_out = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.sys_en = 1'b0; bus.car_in = '0; bus.car_out = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (bus.traffic_jam !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", bus.traffic_jam);
        else n_pass++;
        n_chk++;
        if (bus.jam_opp_en !== 1'b0) $display("FAIL reset_opp_en got=%b exp=0", bus.jam_opp_en);
        else n_pass++;
        n_chk++;
        if (bus.jam_start !== 1'b0) $display("FAIL reset_start got=%b exp=0", bus.jam_start);
        else n_pass++;
        n_chk++;
        if (bus.jam_rotation !== 1'b0) $display("FAIL reset_rotation got=%b exp=0", bus.jam_rotation);
        else n_pass++;
    endtask

    task automatic test_jam_entry();
        for (int k = 0; k < 8; k++) cyc(1'b1, 4'b0100, 4'b0000);
        n_chk++;
        if (bus.traffic_jam !== 4'b0000) $display("FAIL entry_flag_lag got=%b exp=0000", bus.traffic_jam);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.traffic_jam, bus.jam_opp_en} !== {4'b0100, 1'b0})
            $display("FAIL entry_flag_set got=%b/%b exp=0100/0", bus.traffic_jam, bus.jam_opp_en);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !== 3'b110)
            $display("FAIL entry_start got=%b%b%b exp=110", bus.jam_opp_en, bus.jam_start, bus.jam_rotation);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.jam_opp_en, bus.jam_start} !== 2'b10)
            $display("FAIL entry_start_width got=%b%b exp=10", bus.jam_opp_en, bus.jam_start);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int dut_pulses = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 4'b0000, 4'b0000);
            if (bus.jam_rotation === 1'b1) dut_pulses++;
            n_chk++;
            if ({bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !== {m_active, m_start, m_rot})
                $display("FAIL rotation_cycle age=%0d got=%b%b%b exp=%b%b%b", m_age,
                         bus.jam_opp_en, bus.jam_start, bus.jam_rotation, m_active, m_start, m_rot);
            else n_pass++;
        end
        n_chk++;
        if (dut_pulses != 2) $display("FAIL rotation_count got=%0d exp=2", dut_pulses);
        else n_pass++;
    endtask

    task automatic test_hysteresis();
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0000, 4'b0100);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.traffic_jam[2] !== 1'b1) $display("FAIL hyst_hold_at5 got=%b exp=1", bus.traffic_jam[2]);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b0100);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.traffic_jam[2], bus.jam_opp_en} !== 2'b01)
            $display("FAIL hyst_clear_at4 got=%b/%b exp=0/1", bus.traffic_jam[2], bus.jam_opp_en);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.jam_opp_en !== 1'b0) $display("FAIL hyst_exit got=%b exp=0", bus.jam_opp_en);
        else n_pass++;
    endtask

    task automatic test_sys_en_drop();
        int guard = 0;
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'b0100, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.jam_start !== 1'b1) $display("FAIL sysen_first_start got=%b exp=1", bus.jam_start);
        else n_pass++;
        while (m_age != 15 && guard < 40) begin
            cyc(1'b1, 4'b0000, 4'b0000);
            guard++;
        end
        n_chk++;
        if (guard >= 40 || bus.jam_rotation !== 1'b0)
            $display("FAIL sysen_reach_15 guard=%0d rot=%b exp_rot=0", guard, bus.jam_rotation);
        else n_pass++;
        cyc(1'b0, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !== 3'b000)
            $display("FAIL sysen_drop got=%b%b%b exp=000", bus.jam_opp_en, bus.jam_start, bus.jam_rotation);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !== 3'b110)
            $display("FAIL sysen_restart got=%b%b%b exp=110", bus.jam_opp_en, bus.jam_start, bus.jam_rotation);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 40; k++) cyc(1'b1, 4'b0001, 4'b0000);
        for (int k = 0; k < 22; k++) cyc(1'b1, 4'b0000, 4'b0001);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.traffic_jam[0] !== 1'b1) $display("FAIL sat_high_at9 got=%b exp=1", bus.traffic_jam[0]);
        else n_pass++;
        for (int k = 0; k < 5; k++) cyc(1'b1, 4'b0000, 4'b0001);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.traffic_jam[0] !== 1'b0) $display("FAIL sat_clear_at4 got=%b exp=0", bus.traffic_jam[0]);
        else n_pass++;
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0010, 4'b0000);
        cyc(1'b1, 4'b0010, 4'b0010);
        for (int k = 0; k < 5; k++) cyc(1'b1, 4'b0010, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.traffic_jam[1] !== 1'b1) $display("FAIL both_set_at8 got=%b exp=1", bus.traffic_jam[1]);
        else n_pass++;
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'b0000, 4'b0010);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.traffic_jam[1] !== 1'b0) $display("FAIL both_clear_at4 got=%b exp=0", bus.traffic_jam[1]);
        else n_pass++;
        cyc(1'b1, 4'b0000, 4'b1000);
        for (int k = 0; k < 7; k++) cyc(1'b1, 4'b1000, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if (bus.traffic_jam[3] !== 1'b0) $display("FAIL floor_at7 got=%b exp=0", bus.traffic_jam[3]);
        else n_pass++;
        cyc(1'b1, 4'b1000, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        n_chk++;
        if ({bus.traffic_jam, bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !==
            {m_flag, m_active, m_start, m_rot})
            $display("FAIL sat_model got=%b%b%b%b exp=%b%b%b%b", bus.traffic_jam, bus.jam_opp_en,
                     bus.jam_start, bus.jam_rotation, m_flag, m_active, m_start, m_rot);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            logic       s;
            logic [3:0] ci, co;
            int         in_pct;
            in_pct = ((k / 150) % 2 == 0) ? 45 : 20;
            s = ($urandom_range(0, 15) != 0);
            for (int i = 0; i < 4; i++) begin
                ci[i] = ($urandom_range(0, 99) < in_pct);
                co[i] = ($urandom_range(0, 99) < 30);
            end
            cyc(s, ci, co);
            n_chk++;
            if ({bus.traffic_jam, bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !==
                {m_flag, m_active, m_start, m_rot})
                $display("FAIL random cyc=%0d got=%b%b%b%b exp=%b%b%b%b", k, bus.traffic_jam,
                         bus.jam_opp_en, bus.jam_start, bus.jam_rotation, m_flag, m_active, m_start, m_rot);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!m_active && guard < 60) begin
            cyc(1'b1, 4'b0001, 4'b0000);
            guard++;
        end
        n_chk++;
        if (bus.jam_opp_en !== 1'b1) $display("FAIL rstmid_active got=%b exp=1", bus.jam_opp_en);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.traffic_jam, bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !== 7'b0)
            $display("FAIL rstmid_async got=%b%b%b%b exp=0000000", bus.traffic_jam,
                     bus.jam_opp_en, bus.jam_start, bus.jam_rotation);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 4'b0000, 4'b0000);
            n_chk++;
            if ({bus.traffic_jam, bus.jam_opp_en, bus.jam_start, bus.jam_rotation} !== 7'b0)
                $display("FAIL rstmid_quiet cyc=%0d got=%b%b%b%b exp=0000000", k, bus.traffic_jam,
                         bus.jam_opp_en, bus.jam_start, bus.jam_rotation);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.sys_en = 1'b0; bus.car_in = '0; bus.car_out = '0;
        test_reset();
`ifndef JAM_DEBOUNCE_EN
        test_jam_entry();
        test_rotation();
        test_hysteresis();
        test_sys_en_drop();
        test_saturation();
`endif
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
